// File: rtl/vblank_update_scheduler_pkg.sv
// Shared VGA timing constants and scheduler state type.
package vga_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    GRANT = 2'd2
  } state_t;

  localparam int H_TOTAL  = 768;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

endpackage

// File: rtl/vblank_update_scheduler_if.sv
// Beam counters, request/done inputs and grant/status outputs of the update scheduler.
interface vblank_update_scheduler_if #(
  parameter int N_REQ = 3
);
  logic [9:0]       counter_x;
  logic [9:0]       counter_y;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] done;
  logic [N_REQ-1:0] grant;
  logic             window_open;
  logic             frame_tick;
  logic             timeout;
  logic             overrun;
  logic [N_REQ-1:0] missed;

  modport master (
    output counter_x, counter_y, req, done,
    input  grant, window_open, frame_tick, timeout, overrun, missed
  );

  modport slave (
    input  counter_x, counter_y, req, done,
    output grant, window_open, frame_tick, timeout, overrun, missed
  );
endinterface

// File: rtl/vblank_update_scheduler_rr_pick.sv
// Combinational round-robin picker: first set candidate at or after i_ptr, with wrap.
module rr_pick #(
  parameter int N_REQ = 3,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] i_cand,
  input  logic [IW-1:0]    i_ptr,
  output logic             o_valid,
  output logic [IW-1:0]    o_idx
);
  logic [N_REQ-1:0] w_rot;
  logic [IW-1:0]    w_off;
  logic [IW:0]      w_sum;

  // Rotating the doubled vector puts the pointer position at bit 0.
  assign w_rot   = N_REQ'({i_cand, i_cand} >> i_ptr);
  assign o_valid = |i_cand;

  always_comb begin
    w_off = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = IW'(k);
    end
    w_sum = {1'b0, i_ptr} + {1'b0, w_off};
    o_idx = (w_sum >= (IW+1)'(N_REQ)) ? IW'(w_sum - (IW+1)'(N_REQ)) : w_sum[IW-1:0];
  end
endmodule

// File: rtl/vblank_update_scheduler.sv
// Round-robin scheduler of game-state update slots inside vertical blanking.
// Define VBLANK_SCHED_MISSED_EN to record requesters left unserved at each window close.
//   state | meaning
//   IDLE  | beam visible, no updates permitted
//   ARB   | window open, searching for the next unserved requester
//   GRANT | one requester owns the slot, slot counter running
module vblank_update_scheduler
  import vga_sched_pkg::*;
#(
  parameter int N_REQ    = 3,
  parameter int V_ACTIVE = vga_sched_pkg::V_ACTIVE,
  parameter int MAX_SLOT = 256
) (
  input logic                      clk,
  input logic                      rst,
  vblank_update_scheduler_if.slave bus
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(MAX_SLOT);

  state_t           r_state, w_state;
  logic [IW-1:0]    r_ptr, w_ptr;
  logic [IW-1:0]    r_idx, w_idx;
  logic [N_REQ-1:0] r_served, w_served;
  logic [N_REQ-1:0] r_grant, w_grant;
  logic [CW-1:0]    r_cnt, w_cnt;
  logic             r_window, w_window;
  logic             r_tick, w_tick;
  logic             r_timeout, w_timeout;
  logic             r_overrun, w_overrun;

  logic             w_open, w_close, w_done_hit, w_slot_end, w_pick_valid;
  logic [IW-1:0]    w_pick_idx, w_next_ptr;

  assign w_open     = (bus.counter_y == 10'(V_ACTIVE)) && (bus.counter_x == '0);
  assign w_close    = (bus.counter_y == '0) && (bus.counter_x == '0);
  assign w_done_hit = (r_state == GRANT) && (|(bus.done & r_grant));
  assign w_slot_end = (r_cnt == CW'(MAX_SLOT - 1));
  assign w_next_ptr = (r_idx == IW'(N_REQ - 1)) ? '0 : r_idx + 1'b1;

  rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .i_cand  (bus.req & ~r_served),
    .i_ptr   (r_ptr),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

  always_comb begin
    w_state   = r_state;
    w_ptr     = r_ptr;
    w_idx     = r_idx;
    w_served  = r_served;
    w_grant   = r_grant;
    w_cnt     = r_cnt;
    w_window  = r_window;
    w_tick    = 1'b0;
    w_timeout = 1'b0;
    w_overrun = 1'b0;
    if (w_open) begin
      // A reopen while busy is treated as counter glitch recovery, never as an overrun.
      w_state  = ARB;
      w_window = 1'b1;
      w_tick   = 1'b1;
      w_served = '0;
      w_grant  = '0;
    end else if (w_close) begin
      w_state  = IDLE;
      w_window = 1'b0;
      w_grant  = '0;
      if (r_state == GRANT) begin
        if (w_done_hit) begin
          w_served = r_served | r_grant;
          w_ptr    = w_next_ptr;
        end else begin
          w_overrun = 1'b1;
        end
      end
    end else begin
      case (r_state)
        ARB: begin
          if (w_pick_valid) begin
            w_grant = N_REQ'(1) << w_pick_idx;
            w_idx   = w_pick_idx;
            w_cnt   = '0;
            w_state = GRANT;
          end
        end
        GRANT: begin
          if (w_done_hit || w_slot_end) begin
            w_grant   = '0;
            w_served  = r_served | r_grant;
            w_ptr     = w_next_ptr;
            w_timeout = !w_done_hit;
            w_state   = ARB;
          end else begin
            w_cnt = r_cnt + 1'b1;
          end
        end
        IDLE:    ;
        default: w_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_idx     <= '0;
      r_served  <= '0;
      r_grant   <= '0;
      r_cnt     <= '0;
      r_window  <= 1'b0;
      r_tick    <= 1'b0;
      r_timeout <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_ptr     <= w_ptr;
      r_idx     <= w_idx;
      r_served  <= w_served;
      r_grant   <= w_grant;
      r_cnt     <= w_cnt;
      r_window  <= w_window;
      r_tick    <= w_tick;
      r_timeout <= w_timeout;
      r_overrun <= w_overrun;
    end
  end

  assign bus.grant       = r_grant;
  assign bus.window_open = r_window;
  assign bus.frame_tick  = r_tick;
  assign bus.timeout     = r_timeout;
  assign bus.overrun     = r_overrun;

`ifdef VBLANK_SCHED_MISSED_EN
  logic [N_REQ-1:0] r_missed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_missed <= '0;
    else if (w_close) r_missed <= bus.req & ~w_served;
  end

  assign bus.missed = r_missed;
`else
  assign bus.missed = '0;
`endif
endmodule

// File: tb/tb_vblank_update_scheduler.sv
// Self-checking bench: directed scenarios plus randomized windows against a slot-timeline model.
module tb_vblank_update_scheduler;
  localparam int N  = 3;
  localparam int MS = 16;
  localparam int VA = 480;
`ifdef VBLANK_SCHED_MISSED_EN
  localparam bit MISS_EN = 1'b1;
`else
  localparam bit MISS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vblank_update_scheduler_if #(.N_REQ(N)) bus ();

  vblank_update_scheduler #(.N_REQ(N), .V_ACTIVE(VA), .MAX_SLOT(MS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;
  int ptr_m   = 0;
  logic [N-1:0] miss_m = '0;
  logic [N-1:0] obs_order[$];
  int obs_to, obs_ov, obs_gcyc;

  function automatic logic [2*N+3:0] snap();
    return {bus.grant, bus.window_open, bus.frame_tick, bus.timeout, bus.overrun, bus.missed};
  endfunction

  task automatic tick_edge(input logic [9:0] x, input logic [9:0] y,
                           input logic [N-1:0] rq, input logic [N-1:0] dn);
    bus.counter_x = x;
    bus.counter_y = y;
    bus.req       = rq;
    bus.done      = dn;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.counter_x = 10'd5;
    bus.counter_y = 10'd100;
    bus.req       = '0;
    bus.done      = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    ptr_m  = 0;
    miss_m = '0;
  endtask

  // The model lays out each window as a timeline of slots: requesters in cyclic
  // order from the RR pointer, each slot lasting min(done delay, MS) cycles,
  // one ARB cycle between slots, everything cut at the close edge L.
  task automatic run_window(input logic [N-1:0] R, input int d0, input int d1, input int d2,
                            input int L, input int G);
    int d[N];
    int ord[N];
    int s[N];
    int e[N];
    int K, t, i;
    logic [N-1:0] eg, dn, served, prev;
    logic eto, eov;
    logic [2*N+3:0] exp_v, got_v;
    d[0] = d0; d[1] = d1; d[2] = d2;
    K = 0; t = 1;
    for (int o = 0; o < N; o++) begin
      i = (ptr_m + o) % N;
      if (R[i] && t < L) begin
        ord[K] = i;
        s[K]   = t;
        e[K]   = t + ((d[i] < MS) ? d[i] : MS);
        t      = e[K] + 1;
        K++;
      end
    end
    obs_order.delete();
    obs_to = 0; obs_ov = 0; obs_gcyc = 0; prev = '0;

    tick_edge(10'd0, 10'(VA), R, '0);
    exp_v = {{N{1'b0}}, 1'b1, 1'b1, 1'b0, 1'b0, miss_m};
    got_v = snap();
    n_total++;
    if (got_v !== exp_v) $display("FAIL open got %b exp %b", got_v, exp_v);
    else n_pass++;

    for (t = 1; t <= L; t++) begin
      dn = N'($urandom) & ~R;
      for (int k = 0; k < K; k++)
        if (d[ord[k]] <= MS && s[k] + d[ord[k]] == t) dn[ord[k]] = 1'b1;
      if (t == L) tick_edge(10'd0, 10'd0, R, dn);
      else tick_edge(10'($urandom_range(767, 0)), 10'($urandom_range(524, 481)), R, dn);
      eg = '0; eto = 1'b0; eov = 1'b0;
      if (t < L) begin
        for (int k = 0; k < K; k++) begin
          if (s[k] <= t && t < e[k]) eg[ord[k]] = 1'b1;
          if (e[k] == t && d[ord[k]] > MS) eto = 1'b1;
        end
        exp_v = {eg, 1'b1, 1'b0, eto, 1'b0, miss_m};
      end else begin
        served = '0;
        for (int k = 0; k < K; k++) begin
          if (e[k] < L || (e[k] == L && d[ord[k]] <= MS)) begin
            served[ord[k]] = 1'b1;
            ptr_m = (ord[k] + 1) % N;
          end else begin
            eov = 1'b1;
          end
        end
        if (MISS_EN) miss_m = R & ~served;
        exp_v = {{N{1'b0}}, 1'b0, 1'b0, 1'b0, eov, miss_m};
      end
      got_v = snap();
      n_total++;
      if (got_v !== exp_v) $display("FAIL window t=%0d got %b exp %b", t, got_v, exp_v);
      else n_pass++;
      if (bus.grant != '0 && bus.grant != prev) obs_order.push_back(bus.grant);
      if (bus.grant != '0) obs_gcyc++;
      prev = bus.grant;
      obs_to += int'(bus.timeout);
      obs_ov += int'(bus.overrun);
    end

    for (int g = 0; g < G; g++) begin
      tick_edge(10'($urandom_range(767, 0)), 10'($urandom_range(479, 1)), R, N'($urandom));
      exp_v = {{N{1'b0}}, 1'b0, 1'b0, 1'b0, 1'b0, miss_m};
      got_v = snap();
      n_total++;
      if (got_v !== exp_v) $display("FAIL idle g=%0d got %b exp %b", g, got_v, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_total++;
    if (snap() !== '0) $display("FAIL reset_state got %b exp 0", snap());
    else n_pass++;
    tick_edge(10'd0, 10'(VA), 3'b010, '0);
    tick_edge(10'd7, 10'd481, 3'b010, '0);
    n_total++;
    if (bus.grant !== 3'b010) $display("FAIL pre_reset_grant got %b exp 010", bus.grant);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if (snap() !== '0) $display("FAIL reset_async got %b exp 0", snap());
    else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    ptr_m = 0; miss_m = '0;
    for (int c = 0; c < 3; c++) begin
      tick_edge(10'd9, 10'd200, 3'b111, '0);
      n_total++;
      if (snap() !== '0) $display("FAIL idle_after_reset got %b exp 0", snap());
      else n_pass++;
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] want[3];
    want[0] = 3'b001; want[1] = 3'b010; want[2] = 3'b100;
    do_reset();
    run_window(3'b111, 4, 4, 4, 30, 3);
    n_total++;
    if (obs_order.size() != 3) $display("FAIL rr_count got %0d exp 3", obs_order.size());
    else n_pass++;
    for (int k = 0; k < 3 && k < obs_order.size(); k++) begin
      n_total++;
      if (obs_order[k] !== want[k]) $display("FAIL rr_order[%0d] got %b exp %b", k, obs_order[k], want[k]);
      else n_pass++;
    end
  endtask

  task automatic test_timeout();
    do_reset();
    run_window(3'b001, 30, 1, 1, 40, 2);
    n_total++;
    if (obs_gcyc != MS) $display("FAIL slot_len got %0d exp %0d", obs_gcyc, MS);
    else n_pass++;
    n_total++;
    if (obs_to != 1) $display("FAIL timeout_count got %0d exp 1", obs_to);
    else n_pass++;
    n_total++;
    if (obs_order.size() != 1) $display("FAIL no_regrant got %0d exp 1", obs_order.size());
    else n_pass++;
  endtask

  task automatic test_overrun();
    do_reset();
    run_window(3'b001, 30, 1, 1, 8, 2);
    n_total++;
    if (obs_ov != 1) $display("FAIL overrun_count got %0d exp 1", obs_ov);
    else n_pass++;
  endtask

  task automatic test_done_at_close();
    do_reset();
    run_window(3'b001, 4, 1, 1, 5, 2);
    n_total++;
    if (obs_ov != 0) $display("FAIL done_close_overrun got %0d exp 0", obs_ov);
    else n_pass++;
    n_total++;
    if (bus.missed !== 3'b000) $display("FAIL done_close_missed got %b exp 000", bus.missed);
    else n_pass++;
  endtask

  task automatic test_missed();
    do_reset();
    run_window(3'b110, 1, 30, 30, 25, 2);
    n_total++;
    if (bus.missed !== (MISS_EN ? 3'b100 : 3'b000))
      $display("FAIL missed got %b exp %b", bus.missed, MISS_EN ? 3'b100 : 3'b000);
    else n_pass++;
  endtask

  task automatic test_reopen();
    logic [2*N+3:0] exp_v;
    do_reset();
    tick_edge(10'd0, 10'(VA), 3'b001, '0);
    tick_edge(10'd7, 10'd481, 3'b001, '0);
    n_total++;
    if (bus.grant !== 3'b001) $display("FAIL reopen_first_grant got %b exp 001", bus.grant);
    else n_pass++;
    tick_edge(10'd9, 10'd482, 3'b001, '0);
    tick_edge(10'd0, 10'(VA), 3'b001, '0);
    exp_v = {3'b000, 1'b1, 1'b1, 1'b0, 1'b0, miss_m};
    n_total++;
    if (snap() !== exp_v) $display("FAIL reopen_restart got %b exp %b", snap(), exp_v);
    else n_pass++;
    tick_edge(10'd3, 10'd481, 3'b001, '0);
    n_total++;
    if (bus.grant !== 3'b001) $display("FAIL reopen_regrant got %b exp 001", bus.grant);
    else n_pass++;
    tick_edge(10'd0, 10'd0, 3'b001, '0);
    if (MISS_EN) miss_m = 3'b001;
    exp_v = {3'b000, 1'b0, 1'b0, 1'b0, 1'b1, miss_m};
    n_total++;
    if (snap() !== exp_v) $display("FAIL reopen_close got %b exp %b", snap(), exp_v);
    else n_pass++;
    tick_edge(10'd4, 10'd50, 3'b000, '0);
  endtask

  task automatic test_random();
    for (int w = 0; w < 25; w++)
      run_window(N'($urandom), int'($urandom_range(24, 1)), int'($urandom_range(24, 1)),
                 int'($urandom_range(24, 1)), int'($urandom_range(70, 1)),
                 int'($urandom_range(5, 1)));
  endtask

  initial begin
    bus.counter_x = '0;
    bus.counter_y = 10'd100;
    bus.req       = '0;
    bus.done      = '0;
    test_reset();
    test_round_robin();
    test_timeout();
    test_overrun();
    test_done_at_close();
    test_missed();
    test_reopen();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end
endmodule
